// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver: serial shift/latch driver for a cascade of 74HC595 registers
module hc595_chain_driver #(
    parameter int N_CHIP    = 2,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [8*N_CHIP-1:0] data,
    input  logic                en,
    input  logic                mode,
    input  logic                start,
    output logic                ds,
    output logic                shcp,
    output logic                stcp,
    output logic                oe_n,
    output logic                busy,
    output logic                done
);
    localparam int W  = 8 * N_CHIP;
    localparam int BW = $clog2(W);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t          state, state_d;
    logic [W-1:0]    sh, sh_d;
    logic [BW-1:0]   cnt, cnt_d;
    logic [DW-1:0]   div, div_d;
    logic            latched_once, latched_d;
    logic            ds_d, shcp_d, stcp_d, oe_n_d, busy_d, done_d;
    logic            tick;

    // Register every output and the frame state; async clear aborts any transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sh           <= '0;
            cnt          <= '0;
            div          <= '0;
            latched_once <= 1'b0;
            ds           <= 1'b0;
            shcp         <= 1'b0;
            stcp         <= 1'b0;
            oe_n         <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            sh           <= sh_d;
            cnt          <= cnt_d;
            div          <= div_d;
            latched_once <= latched_d;
            ds           <= ds_d;
            shcp         <= shcp_d;
            stcp         <= stcp_d;
            oe_n         <= oe_n_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Next-state logic: divider ticks toggle shcp in SHIFT and end the stcp pulse in LATCH
    always_comb begin
        tick      = (div == LAST_DIV);
        state_d   = state;
        sh_d      = sh;
        cnt_d     = cnt;
        div_d     = tick ? '0 : div + DW'(1);
        latched_d = latched_once;
        ds_d      = ds;
        shcp_d    = shcp;
        stcp_d    = stcp;
        busy_d    = busy;
        done_d    = 1'b0;
        oe_n_d    = ~(latched_once & en);
        case (state)
            IDLE: begin
                div_d = '0;
                if (en && (mode || start)) begin
                    state_d = SHIFT;
                    sh_d    = data;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    shcp_d  = 1'b0;
                    ds_d    = (MSB_FIRST != 0) ? data[W-1] : data[0];
                end
            end
            SHIFT: begin
                if (tick && !shcp) begin
                    shcp_d = 1'b1;
                end else if (tick) begin
                    shcp_d = 1'b0;
                    if (cnt == LAST_BIT) begin
                        state_d = LATCH;
                        stcp_d  = 1'b1;
                        ds_d    = 1'b0;
                    end else begin
                        cnt_d = cnt + BW'(1);
                        sh_d  = (MSB_FIRST != 0) ? sh << 1 : sh >> 1;
                        ds_d  = (MSB_FIRST != 0) ? sh[W-2] : sh[1];
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    stcp_d    = 1'b0;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    latched_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hc595_chain_driver.sv
// tb_hc595_chain_driver: scoreboard bench for the 595 chain driver (MSB-first and LSB-first instances)
module tb_hc595_chain_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic        lmode = 1'b0;
    logic        lstart = 1'b0;
    logic [15:0] data = 16'h0;
    logic [15:0] ldata = 16'h0;
    logic        ds0, shcp0, stcp0, oe_n0, busy0, done0;
    logic        ds1, shcp1, stcp1, oe_n1, busy1, done1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    logic [15:0] word[2];
    int          nrise[2], total_rise[2], total_stcp[2], nst[2], stw[2], lastw[2];
    int          cyc_f[2], busy_low[2], frames[2], last_done[2];
    logic        shcp_q[2], stcp_q[2], busy_q[2];
    int          cyc = 0;
    bit          cont_chk = 1'b0;

    hc595_chain_driver #(.N_CHIP(2), .CLK_DIV(4), .MSB_FIRST(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .data(data), .en(en), .mode(mode), .start(start),
        .ds(ds0), .shcp(shcp0), .stcp(stcp0), .oe_n(oe_n0), .busy(busy0), .done(done0)
    );

    hc595_chain_driver #(.N_CHIP(2), .CLK_DIV(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .data(ldata), .en(en), .mode(lmode), .start(lstart),
        .ds(ds1), .shcp(shcp1), .stcp(stcp1), .oe_n(oe_n1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-channel monitor: collects ds at shcp rises, measures stcp and frame timing, checks on done
    task automatic mon(input int c, input logic ds_i, input logic shcp_i, input logic stcp_i,
                       input logic busy_i, input logic done_i);
        logic [15:0] e;
        if (!rst_n) begin
            word[c] = '0; nrise[c] = 0; nst[c] = 0; stw[c] = 0; lastw[c] = 0;
            cyc_f[c] = 0; busy_low[c] = 0; last_done[c] = -1;
            shcp_q[c] = 1'b0; stcp_q[c] = 1'b0; busy_q[c] = 1'b0;
            return;
        end
        if (!cont_chk) last_done[c] = -1;
        if (shcp_i && !shcp_q[c]) begin
            word[c] = (c == 0) ? {word[c][14:0], ds_i} : {ds_i, word[c][15:1]};
            nrise[c]++;
            total_rise[c]++;
        end
        if (stcp_i && !stcp_q[c]) begin
            nst[c]++;
            total_stcp[c]++;
        end
        if (stcp_i) stw[c]++;
        if (!stcp_i && stcp_q[c]) begin
            lastw[c] = stw[c];
            stw[c] = 0;
        end
        if ((nrise[c] > 0 || stcp_i) && !busy_i && !done_i) busy_low[c]++;
        cyc_f[c] = (busy_i && !busy_q[c]) ? 0 : cyc_f[c] + 1;
        if (done_i) begin
            if ((c == 0 ? q0.size() : q1.size()) == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame ch%0d: got word %0h, expected no frame", c, word[c]);
            end else begin
                e = (c == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("frame_word_ch%0d", c), word[c], e);
            end
            chk($sformatf("shcp_rises_ch%0d", c), nrise[c], 16);
            chk($sformatf("stcp_pulses_ch%0d", c), nst[c], 1);
            chk($sformatf("stcp_width_ch%0d", c), lastw[c], 4);
            chk($sformatf("frame_len_ch%0d", c), cyc_f[c], 132);
            chk($sformatf("busy_hold_ch%0d", c), busy_low[c], 0);
            if (cont_chk && last_done[c] >= 0)
                chk($sformatf("cont_period_ch%0d", c), cyc - last_done[c], 133);
            last_done[c] = cyc;
            frames[c]++;
            word[c] = '0; nrise[c] = 0; nst[c] = 0; busy_low[c] = 0;
        end
        shcp_q[c] = shcp_i;
        stcp_q[c] = stcp_i;
        busy_q[c] = busy_i;
    endtask

    // Sample outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc++;
        mon(0, ds0, shcp0, stcp0, busy0, done0);
        mon(1, ds1, shcp1, stcp1, busy1, done1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int c, input int budget);
        int k = 0;
        while (!(c == 0 ? done0 : done1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("done_seen_ch%0d", c), (c == 0) ? done0 : done1, 1);
    endtask

    task automatic wait_rise(input int c, input int n, input int budget);
        int k = 0;
        while (nrise[c] < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("rise_seen_ch%0d", c), nrise[c] >= n, 1);
    endtask

    task automatic fire(input logic [15:0] w, input bit expect_frame);
        data = w;
        if (expect_frame) q0.push_back(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int r, s;
        en = 1'b1;
        cycles(3);
        chk("rst_ds", ds0, 0);
        chk("rst_shcp", shcp0, 0);
        chk("rst_stcp", stcp0, 0);
        chk("rst_oe_n", oe_n0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        rst_n = 1'b1;
        cycles(2);

        fire(16'h1234, 1);
        chk("oe_n_before_first", oe_n0, 1);
        chk("busy_in_frame", busy0, 1);
        wait_done(0, 200);
        chk("oe_n_done_cycle", oe_n0, 1);
        @(negedge clk);
        chk("oe_n_after_done", oe_n0, 0);
        chk("busy_after_done", busy0, 0);
        chk("done_one_cycle", done0, 0);

        cycles(3);
        fire(16'h1234, 1);
        wait_rise(0, 5, 200);
        data = 16'h8765;
        wait_done(0, 200);
        cycles(2);
        fire(16'h8765, 1);
        wait_done(0, 200);

        cycles(3);
        data = 16'hA5C3;
        cont_chk = 1'b1;
        q0.push_back(16'hA5C3);
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_done(0, 300);
            q0.push_back(16'hA5C3);
            @(negedge clk);
        end
        wait_rise(0, 3, 300);
        en = 1'b0;
        wait_done(0, 300);
        mode = 1'b0;
        cont_chk = 1'b0;
        r = total_rise[0];
        s = total_stcp[0];
        @(negedge clk);
        chk("oe_n_after_en_drop", oe_n0, 1);
        cycles(300);
        chk("no_shcp_after_en_drop", total_rise[0], r);
        chk("no_stcp_after_en_drop", total_stcp[0], s);
        chk("idle_busy_after_en_drop", busy0, 0);

        en = 1'b1;
        cycles(2);
        ldata = 16'h0001;
        q1.push_back(16'h0001);
        lstart = 1'b1;
        @(negedge clk);
        lstart = 1'b0;
        cycles(20);
        lstart = 1'b1;
        @(negedge clk);
        lstart = 1'b0;
        wait_done(1, 200);
        cycles(150);
        chk("lsb_frames", frames[1], 1);
        chk("lsb_idle_busy", busy1, 0);

        cycles(2);
        fire(16'h5A3C, 0);
        wait_rise(0, 7, 200);
        s = total_stcp[0];
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_shcp", shcp0, 0);
        chk("async_busy", busy0, 0);
        chk("async_oe_n", oe_n0, 1);
        cycles(3);
        rst_n = 1'b1;
        r = total_rise[0];
        cycles(50);
        chk("post_rst_ds", ds0, 0);
        chk("post_rst_shcp_idle", total_rise[0], r);
        chk("post_rst_stcp", total_stcp[0], s);
        chk("post_rst_busy", busy0, 0);
        chk("post_rst_oe_n", oe_n0, 1);
        fire(16'h5A3C, 1);
        wait_done(0, 200);
        cycles(3);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
